// File: rtl/rtype_issue_unit.sv
// R-type issuer: encodes symbolic requests, queues them in a small FIFO,
// drives one word per cycle to the core and captures its result as a writeback record.
module rtype_issue_unit #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_op,
    input  logic [4:0]                 req_rs,
    input  logic [4:0]                 req_rt,
    input  logic [4:0]                 req_rd,
    input  logic [4:0]                 req_shamt,
    output logic                       req_err,
    input  logic                       stall,
    output logic [31:0]                instruction,
    output logic                       issue_valid,
    input  logic [31:0]                core_result,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    output logic [31:0]                wb_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [5:0]  funct;
    logic        legal;
    logic        shift;
    logic [31:0] enc;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        funct = 6'h00;
        legal = 1'b1;
        shift = 1'b0;
        unique case (req_op)
            4'd0:  funct = 6'h20;
            4'd1:  funct = 6'h21;
            4'd2:  funct = 6'h22;
            4'd3:  funct = 6'h23;
            4'd4:  funct = 6'h24;
            4'd5:  funct = 6'h25;
            4'd6:  funct = 6'h2A;
            4'd7:  funct = 6'h2B;
            4'd8:  begin funct = 6'h00; shift = 1'b1; end
            4'd9:  begin funct = 6'h02; shift = 1'b1; end
            4'd10: begin funct = 6'h03; shift = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    // Shifts carry no rs operand; non-shifts carry no shift amount.
    assign enc = {6'b000000,
                  shift ? 5'd0 : req_rs,
                  req_rt,
                  req_rd,
                  shift ? req_shamt : 5'd0,
                  funct};

    assign req_ready = (count < FULL) && !rst;
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal;
    assign pop       = (count != '0) && !stall;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_err     <= 1'b0;
            instruction <= 32'h0;
            issue_valid <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'h0;
        end else begin
            req_err <= accept && !legal;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                instruction <= mem[rd_ptr];
                issue_valid <= 1'b1;
            end else begin
                instruction <= 32'h0;
                issue_valid <= 1'b0;
            end

            if (issue_valid) begin
                wb_valid <= 1'b1;
                wb_rd    <= instruction[15:11];
                wb_data  <= core_result;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rtype_issue_unit.md
# rtype_issue_unit

Instruction issuer on the driving side of the single-cycle MIPS32 R-type datapath. Accepts symbolic operation requests over a valid/ready handshake and encodes each into a 32-bit R-type word. Requests are queued in a small FIFO and presented one per cycle on the core's instruction input. The core's combinational result is captured as a tagged writeback record for checking and tracing.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted; equals (count < DEPTH) and not rst.
- req_op  in  4  operation code, see Operation.
- req_rs / req_rt / req_rd  in  5 each  register fields.
- req_shamt  in  5  shift amount.
- req_err  out  1  one-cycle pulse: illegal op consumed.
- stall  in  1  inhibits issue while high.
- instruction  out  32  registered word driven to the core.
- issue_valid  out  1  instruction holds a real issued op.
- core_result  in  32  core ALU result for the current instruction.
- wb_valid  out  1  one-cycle pulse: writeback record valid.
- wb_rd  out  5  destination of the captured result.
- wb_data  out  32  captured core_result.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Op map to funct:
  - 0 add 0x20, 1 addu 0x21, 2 sub 0x22, 3 subu 0x23, 4 and 0x24, 5 or 0x25.
  - 6 slt 0x2A, 7 sltu 0x2B.
  - 8 sll 0x00, 9 srl 0x02, 10 sra 0x03.
  - Ops 11–15 are illegal.
- Encoding: [31:26]=0, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=shamt, [5:0]=funct.
  - Shifts (ops 8–10): rs field forced to 0.
  - Non-shifts: shamt field forced to 0.
  - Encoding happens at push; the FIFO stores the encoded 32-bit word.
- Accept occurs when req_valid && req_ready at an edge.
  - Legal op: word pushed at the tail.
  - Illegal op: request consumed, nothing pushed, req_err=1 for the next cycle only.
- Issue: at each edge with count>0 and !stall, the head is popped into instruction and issue_valid<=1.
  - Otherwise instruction<=0x00000000 (nop, sll $0,$0,0) and issue_valid<=0.
- Writeback: at each edge with issue_valid=1, wb_data<=core_result, wb_rd<=instruction[15:11], wb_valid<=1.
  - Otherwise wb_valid<=0; wb_rd and wb_data hold their values.
  - rd=0 is issued and reported normally.
- Push and pop in the same edge: count unchanged, order preserved.
- No bypass: a request is never issued in the cycle it is accepted.
- Full (count=DEPTH): req_ready=0; an illegal op is not consumed and raises no error.
- Pointers wrap modulo DEPTH; count is the authoritative full/empty indicator.

## Timing
- Reset values while rst is high:
  - req_ready=0, req_err=0.
  - instruction=0, issue_valid=0.
  - wb_valid=0, wb_rd=0, wb_data=0.
  - count=0, FIFO pointers 0.
- Reset asserted mid-operation discards all queued and in-flight entries immediately. No wb_valid is produced for the instruction that was on the bus.
- Latency, empty FIFO and stall=0:
  - accept at edge E0;
  - instruction and issue_valid valid after E1;
  - wb_valid after E2.
- Throughput: one issue per cycle, back-to-back, while count>0 and stall=0.
- stall sampled at the edge; raising it yields a nop on the next cycle. The FIFO keeps accepting until full.
- core_result must be stable before the edge following the issue. The core writes its register file at that same edge.

## Test plan
- Reset -> all outputs at reset values; after release req_ready=1, count=0, instruction=0.
- add, op=0 rs=1 rt=2 rd=3 -> instruction=0x00221820 after E1; with core_result=0x0000000A, wb_valid=1, wb_rd=3, wb_data=0x0000000A after E2.
- sll, op=8 rs=7 rt=4 rd=5 shamt=3 -> rs forced to 0, instruction=0x000428C0.
- stall=1, push 5 requests -> count=4 and req_ready=0, 5th request held. Drop stall -> 4 issues on consecutive cycles in push order, then the 5th is accepted.
- op=12 accepted -> req_err pulses for 1 cycle, count unchanged, issue_valid stays 0.
- count=2 with simultaneous push and pop -> count stays 2. Assert rst mid-burst -> count=0 and issue_valid=0 immediately, with no wb_valid afterwards.
